div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: ports clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request a division using the operands presented this cycle.
REQ-005 cancel  input  1  abort the operation in progress (pipeline flush or exception).
REQ-006 is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-007 dividend  input  32  rs operand, driven from register-file read port 1; sampled with start.
REQ-008 divisor  input  32  rt operand, driven from register-file read port 2; sampled with start.
REQ-009 busy  output  1  operation in progress; the consumer stalls on it.
REQ-010 done  output  1  one-cycle pulse; results valid.
REQ-011 quotient  output  32  result written to LO.
REQ-012 remainder  output  32  result written to HI.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX and DONE, all registered.
REQ-014 IDLE or DONE, start=1, cancel=0 -> latch operands as magnitudes (absolute values if is_signed), latch result signs, clear the 6-bit iteration counter, go to RUN.
REQ-015 RUN SHALL perform one restoring shift-subtract step per cycle, exactly 32 steps.
REQ-016 After the 32nd step, RUN -> FIX.
REQ-017 FIX SHALL apply the signs, register quotient and remainder, and go to DONE.
REQ-018 DONE SHALL last exactly 1 cycle.
REQ-019 DONE -> IDLE, unless start=1, in which case REQ-014 applies.
REQ-020 Latency: start sampled at edge N -> done=1 in the cycle following edge N+34; quotient and remainder valid in that same cycle.
REQ-021 busy=1 in RUN and FIX only; done=1 in DONE only; never both high together.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 Operands and is_signed SHALL be used only as sampled with start; later input changes have no effect.
REQ-024 Signed rules: quotient truncates toward zero; quotient is negative iff the operand signs differ and quotient is nonzero; remainder takes the sign of the dividend.
REQ-025 Signed overflow 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0x00000000.
REQ-026 Divisor 0 (either mode) -> quotient 0xFFFFFFFF, remainder = dividend as given; full latency; no error signal.
REQ-027 cancel=1 in RUN or FIX -> IDLE at the next edge; no done pulse; quotient and remainder keep their previous values.
REQ-028 cancel=1 in IDLE or DONE SHALL block a same-cycle start; cancel has priority over start.
REQ-029 quotient and remainder SHALL hold their values from done until the next FIX completes.

Reset
REQ-030 rst=1 -> at the next edge: state IDLE, busy=0, done=0, quotient=0, remainder=0, counter=0.
REQ-031 rst=1 overrides start and cancel in any state; an operation in progress is abandoned without a done pulse.
REQ-032 With rst=1, all outputs SHALL be at reset values from the first edge onward.

Verification
REQ-033 DIVU 100/7, start at edge N -> busy=1 from N+1 to N+34; done=1 only in the cycle after edge N+34; quotient=14, remainder=2.
REQ-034 DIV 0xFFFFFFF9 / 0x00000002 (-7/2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-035 DIVU and DIV 0x00001234 / 0 -> quotient=0xFFFFFFFF, remainder=0x00001234, same latency as REQ-033.
REQ-036 Cancel: start 100/7, cancel=1 in the 10th busy cycle -> busy=0 next cycle, no done pulse, outputs keep prior results. A new start next cycle (50/5) -> quotient=10, remainder=0.
REQ-037 Reset and back-to-back: rst mid-RUN -> all outputs 0, no done. Also: start held high across DONE -> second operation accepted in the DONE cycle; the second start pulse while busy is ignored.

Source files
------------

// File: rtl/div_unit.sv
// 32-bit iterative restoring divider for DIV/DIVU.
// An accepted start occupies 33 RUN cycles, then one FIX cycle, then one DONE cycle.
// RUN spends 32 cycles on shift-subtract steps. Its final cycle, with the counter at 32,
// only hands off to FIX, which applies the result signs.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cancel,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;    // dividend magnitude, becomes quotient magnitude
    logic [31:0] dvs_q, dvs_d;    // divisor magnitude
    logic [31:0] part_q, part_d;  // partial remainder
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dz_q, dz_d;      // divide by zero
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] part_shift;
    logic        fits;

    assign a_neg      = is_signed & dividend[31];
    assign b_neg      = is_signed & divisor[31];
    assign a_mag      = a_neg ? (32'd0 - dividend) : dividend;
    assign b_mag      = b_neg ? (32'd0 - divisor) : divisor;
    assign part_shift = {part_q, dvd_q[31]};
    assign fits       = part_shift >= {1'b0, dvs_q};

    // Next-state and datapath logic.
    // Cancel outranks start. Results only change in FIX.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        part_d  = part_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start && !cancel) begin
                    state_d = StRun;
                    cnt_d   = 6'd0;
                    dvd_d   = a_mag;
                    dvs_d   = b_mag;
                    part_d  = 32'd0;
                    dz_d    = (divisor == 32'd0);
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                end
            end
            StRun: begin
                if (cancel) begin
                    state_d = StIdle;
                end else if (cnt_q == 6'd32) begin
                    state_d = StFix;
                end else begin
                    // Divisor 0 always fits; low 32 bits then just collect the dividend.
                    part_d = fits ? (part_shift[31:0] - dvs_q) : part_shift[31:0];
                    dvd_d  = {dvd_q[30:0], fits};
                    cnt_d  = cnt_q + 6'd1;
                end
            end
            StFix: begin
                if (cancel) begin
                    state_d = StIdle;
                end else begin
                    state_d = StDone;
                    quo_d   = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? (32'd0 - dvd_q) : dvd_q);
                    rem_d   = r_neg_q ? (32'd0 - part_q) : part_q;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StRun) || (state_d == StFix);
        done_d = (state_d == StDone);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 6'd0;
            dvd_q   <= 32'd0;
            dvs_q   <= 32'd0;
            part_q  <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            part_q  <= part_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized DIV/DIVU
// operations compared against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cancel;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_tests = 0;
    int n_fail  = 0;

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cancel    (cancel),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic plus the architectural special cases.
    task automatic model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endtask

    // Issue one operation at the current negedge, wait for done, check latency and results.
    // Operands are scrambled after the start edge; optionally a stray start is pulsed mid-run.
    task automatic do_div(input string tag, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit pulse);
        logic [31:0] eq, er;
        int done_at = 0;
        int busy_cnt = 0;
        int overlap = 0;
        model(sgn, a, b, eq, er);
        start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy && done) overlap++;
            if (done) begin
                done_at = k;
                break;
            end
            if (busy) busy_cnt++;
            if (k == 1) begin
                start = 1'b0;
                is_signed = $urandom_range(0, 1);
                dividend = $urandom;
                divisor = $urandom;
            end
            if (pulse && k == 5) start = 1'b1;
            if (k == 6) start = 1'b0;
        end
        check_eq({tag, " done_cycle"}, done_at, 35);
        check_eq({tag, " busy_cycles"}, busy_cnt, 34);
        check_eq({tag, " overlap"}, overlap, 0);
        check_eq({tag, " quotient"}, quotient, eq);
        check_eq({tag, " remainder"}, remainder, er);
    endtask

    logic [31:0] eq_a, er_a, eq_b, er_b;
    int          cnt;

    initial begin
        rst = 1'b1; start = 1'b1; cancel = 1'b0; is_signed = 1'b0;
        dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst busy", busy, 0);
        check_eq("rst done", done, 0);
        check_eq("rst quotient", quotient, 0);
        check_eq("rst remainder", remainder, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check_eq("idle busy", busy, 0);

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        check_eq("q14", quotient, 32'd14);
        check_eq("r2", remainder, 32'd2);
        @(negedge clk);
        check_eq("done_pulse_len", done, 0);
        check_eq("hold_q", quotient, 32'd14);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_eq("q_m3", quotient, 32'hFFFF_FFFD);
        check_eq("r_m1", remainder, 32'hFFFF_FFFF);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check_eq("ovf_q", quotient, 32'h8000_0000);
        do_div("divu_by0", 1'b0, 32'h0000_1234, 32'd0, 1'b0);
        check_eq("by0_q", quotient, 32'hFFFF_FFFF);
        do_div("div_by0", 1'b1, 32'h0000_1234, 32'd0, 1'b0);
        check_eq("by0_r", remainder, 32'h0000_1234);
        do_div("div_neg_by0", 1'b1, 32'hFFFF_FF00, 32'd0, 1'b1);

        // Cancel in the 10th busy cycle, prior results 14/2 must survive.
        do_div("pre_cancel", 1'b0, 32'd100, 32'd7, 1'b0);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        cancel = 1'b1;
        @(negedge clk);
        check_eq("cancel busy", busy, 0);
        check_eq("cancel done", done, 0);
        check_eq("cancel q", quotient, 32'd14);
        check_eq("cancel r", remainder, 32'd2);
        // Cancel in IDLE blocks a same-cycle start.
        start = 1'b1;
        @(negedge clk);
        check_eq("cancel_blocks_start", busy, 0);
        cancel = 1'b0;
        do_div("after_cancel", 1'b0, 32'd50, 32'd5, 1'b0);
        check_eq("q10", quotient, 32'd10);
        check_eq("r0", remainder, 32'd0);

        // Reset mid-RUN.
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst busy", busy, 0);
        check_eq("mid_rst done", done, 0);
        check_eq("mid_rst q", quotient, 0);
        check_eq("mid_rst r", remainder, 0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check_eq("mid_rst no_activity", cnt, 0);

        // Back-to-back: start held high; second operands presented while busy are used
        // only when the DONE cycle accepts them.
        model(1'b0, 32'd200, 32'd9, eq_a, er_a);
        model(1'b1, 32'hFFFF_FF9C, 32'd7, eq_b, er_b);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd200; divisor = 32'd9;
        @(negedge clk);
        is_signed = 1'b1; dividend = 32'hFFFF_FF9C; divisor = 32'd7;
        cnt = 0;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                cnt = k;
                break;
            end
        end
        check_eq("b2b first done_cycle", cnt, 35);
        check_eq("b2b first q", quotient, eq_a);
        check_eq("b2b first r", remainder, er_a);
        @(negedge clk);
        start = 1'b0;
        check_eq("b2b accepted busy", busy, 1);
        check_eq("b2b accepted done", done, 0);
        cnt = 0;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                cnt = k;
                break;
            end
        end
        check_eq("b2b second done_cycle", cnt, 35);
        check_eq("b2b second q", quotient, eq_b);
        check_eq("b2b second r", remainder, er_b);

        // Randomized operations with biased corner operands.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = $urandom_range(0, 15);
                1: b = 32'd0;
                2: b = -($urandom_range(1, 9));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            do_div($sformatf("rand%0d", i), $urandom_range(0, 1), a, b, $urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
